hazard_control_unit: RTL
========================

Name: hazard_control_unit

Overview:
Central pipeline sequencer for the 5-stage segmented core. It owns the enable/flush controls of the PC, IF/DE, DE/EX and EX/MEM pipeline registers, including the enable of the decode-stage program-counter register. It resolves three events:
- load-use hazards
- taken branches/jumps resolved in EX
- data-memory wait states

It also keeps saturating stall/flush performance counters.

Parameters:
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous reset, active-low
de_rs1  in  5  rs1 of instruction in DE
de_rs2  in  5  rs2 of instruction in DE
de_rs1_used  in  1  DE instruction reads rs1
de_rs2_used  in  1  DE instruction reads rs2
ex_rd  in  5  destination of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved taken branch/jump (redirect this cycle)
dmem_req  in  1  MEM stage has an access outstanding
dmem_ready  in  1  data memory completes access this cycle
pc_enable  out  1  PC register update enable
fd_enable  out  1  IF/DE registers enable (drives decode PC register enable)
fd_flush  out  1  IF/DE registers load NOP/zero
de_enable  out  1  DE/EX registers enable
de_flush  out  1  DE/EX registers load bubble
em_enable  out  1  EX/MEM registers enable
stall_cycles  out  CNT_W  count of cycles with pc_enable=0, saturating
flush_count  out  CNT_W  count of taken-branch flushes, saturating

Behaviour:
- Reset:
  - One clock; reset is synchronous and active-low: sampled on the clk rising edge while rst=0.
  - State becomes RUN; load-stall counter, stall_cycles and flush_count become 0.
  - While rst=0, all *_enable outputs are 0 and fd_flush = de_flush = 1.
- Control outputs are combinational from the current state and current inputs. State and counters are registered.
- Signal definitions:
  - mem_wait = dmem_req & ~dmem_ready.
  - load_use = ex_mem_read & (ex_rd != 0) & ((de_rs1_used & de_rs1 == ex_rd) | (de_rs2_used & de_rs2 == ex_rd)).
- Priority: mem_wait > ex_branch_taken > load_use. Only one action applies per cycle.
- FSM states: RUN, LD_STALL, MEM_WAIT.
- RUN:
  - No event: all enables 1, flushes 0.
  - mem_wait: all enables 0, flushes 0; next state MEM_WAIT.
  - ex_branch_taken (no mem_wait): all enables 1, fd_flush = de_flush = 1; flush_count increments; stay RUN.
  - load_use (no mem_wait, no branch): pc_enable = fd_enable = 0, de_enable = 1, de_flush = 1, em_enable = 1.
    - If LOAD_STALL_CYCLES > 1: next state LD_STALL with remaining = LOAD_STALL_CYCLES-1.
    - Otherwise stay RUN.
- LD_STALL:
  - Outputs as for load_use; remaining decrements each cycle.
  - When remaining==1, next state RUN.
  - If mem_wait occurs: all enables 0, remaining holds, state stays LD_STALL (nested freeze).
  - ex_branch_taken is ignored, because EX holds a bubble.
- MEM_WAIT:
  - While dmem_ready=0: all enables 0, flushes 0.
  - Cycle with dmem_ready=1: normal RUN evaluation applies in the same cycle (zero-cycle release); next state RUN.
  - A pending branch or load_use is then serviced with normal priority.
  - dmem_req dropping without dmem_ready is treated as ready.
- x0 rule: ex_rd==0 never creates a hazard.
- Counters:
  - stall_cycles increments on every cycle with pc_enable=0 and rst=1.
  - Both counters saturate at 2^CNT_W-1, with no wrap.
- Reset mid-stall or mid-wait: returns to RUN at the next edge; any remaining stall count is discarded.

Decomposition:
- Shared package pipeline_ctrl_pkg: state enum (RUN, LD_STALL, MEM_WAIT), REG_ADDR_W=5, X0 constant.
- One natural sub-module: sat_counter (parameterised width, inc, synchronous active-low clear), instantiated twice.

Test Plan:
- Reset: rst=0 for 2 cycles, then rst=1 with no events -> during reset enables=0 and flushes=1; after reset all enables=1, flushes=0, both counters 0.
- Load-use: ex_mem_read=1, ex_rd=5, de_rs1=5, de_rs1_used=1, LOAD_STALL_CYCLES=1 -> one cycle with pc/fd_enable=0 and de_flush=1; stall_cycles=1.
- x0 and multi-cycle load-use:
  - ex_rd=0 with a matching rs -> no stall.
  - LOAD_STALL_CYCLES=3 -> exactly 3 stall cycles; state returns to RUN.
- Branch: ex_branch_taken=1 for 1 cycle -> fd_flush = de_flush = 1 with enables=1; flush_count=1.
- Memory wait:
  - dmem_req=1, dmem_ready=0 for 4 cycles, then ready -> all enables 0 for 4 cycles; enables 1 in the ready cycle; stall_cycles=4.
  - Simultaneous ex_branch_taken during the wait -> no flush until release.
- Saturation and mid-stall reset:
  - CNT_W=2 with 5 branches -> flush_count=3.
  - rst=0 asserted in LD_STALL -> state RUN and counters 0 at the next edge.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing control logic.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 5;

  // Architectural zero register; writes to it never create a dependency.
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hcu_state_t;

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with a synchronous active-low clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc and stick at all-ones instead of wrapping back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: drives the enable/flush controls of PC, IF/DE, DE/EX
// and EX/MEM registers, resolving data-memory waits, taken branches and
// load-use hazards, and keeps saturating stall/flush counters.
module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] de_rs1,
  input  logic [REG_ADDR_W-1:0] de_rs2,
  input  logic                  de_rs1_used,
  input  logic                  de_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic                  pc_enable,
  output logic                  fd_enable,
  output logic                  fd_flush,
  output logic                  de_enable,
  output logic                  de_flush,
  output logic                  em_enable,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  // Bubbles still owed after the first stall cycle of a load-use hazard.
  localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

  hcu_state_t state, state_next;
  logic [2:0] remaining, remaining_next;
  logic       mem_wait;
  logic       load_use;
  logic       branch_flush;
  logic       stall_inc;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_rd != X0) &
                    ((de_rs1_used & (de_rs1 == ex_rd)) |
                     (de_rs2_used & (de_rs2 == ex_rd)));

  // State and remaining-bubble register; reset discards any pending stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      remaining <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
    end
  end

  // Next-state and control decode. MEM_WAIT shares RUN's evaluation: a
  // completing access releases the pipeline in the same cycle, and an
  // ongoing wait simply freezes again.
  always_comb begin
    pc_enable      = 1'b1;
    fd_enable      = 1'b1;
    fd_flush       = 1'b0;
    de_enable      = 1'b1;
    de_flush       = 1'b0;
    em_enable      = 1'b1;
    branch_flush   = 1'b0;
    state_next     = state;
    remaining_next = remaining;

    if (!rst) begin
      pc_enable      = 1'b0;
      fd_enable      = 1'b0;
      fd_flush       = 1'b1;
      de_enable      = 1'b0;
      de_flush       = 1'b1;
      em_enable      = 1'b0;
      state_next     = RUN;
      remaining_next = '0;
    end else begin
      case (state)
        LD_STALL: begin
          if (mem_wait) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_enable = 1'b0;
            em_enable = 1'b0;
          end else begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_flush  = 1'b1;
            if (remaining <= 3'd1) begin
              state_next     = RUN;
              remaining_next = '0;
            end else begin
              remaining_next = remaining - 3'd1;
            end
          end
        end
        default: begin
          if (mem_wait) begin
            pc_enable  = 1'b0;
            fd_enable  = 1'b0;
            de_enable  = 1'b0;
            em_enable  = 1'b0;
            state_next = MEM_WAIT;
          end else if (ex_branch_taken) begin
            fd_flush     = 1'b1;
            de_flush     = 1'b1;
            branch_flush = 1'b1;
            state_next   = RUN;
          end else if (load_use) begin
            pc_enable = 1'b0;
            fd_enable = 1'b0;
            de_flush  = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_next     = LD_STALL;
              remaining_next = STALL_RELOAD;
            end else begin
              state_next = RUN;
            end
          end else begin
            state_next = RUN;
          end
        end
      endcase
    end
  end

  assign stall_inc = rst & ~pc_enable;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (branch_flush),
    .count (flush_count)
  );

endmodule
